// File: rtl/id_ex_hazard_unit.sv
// id_ex_hazard_unit
// Hazard controller on the consumer side of the ID/EX register. Looks at
// what ID/EX presents to EX and at the instruction sitting in ID. Each cycle
// it decides whether PC and IF/ID advance, whether IF/ID loads a nop, and
// whether ID/EX loads a bubble. Load-use hazards stall; redirects resolved
// in EX flush. A redirect always beats a load-use hazard.
// Optional feature macro: HAZARD_PERF_CNT_EN adds the stall_cycles and
// flush_cycles performance counter outputs.
module id_ex_hazard_unit #(
    parameter int REG_W           = 5,
    parameter int LOAD_STALL_CYCS = 1,
    parameter int FLUSH_CYCS      = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [REG_W-1:0] ex_dst,
    input  logic             ex_redirect,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       hazard_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10,
        ST_ILL   = 2'b11
    } state_t;

    // The first bubble/flush cycle is produced while still in RUN, so the
    // extra states only need to cover the remaining cycles.
    localparam bit       STALL_USE    = (LOAD_STALL_CYCS > 1);
    localparam bit       FLUSH_USE    = (FLUSH_CYCS > 1);
    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCS - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCS - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_use;

    // A bubbled EX stage (RegWrite low) or a write to r0 never creates a hazard.
    assign load_use = ex_mem_read & ex_reg_write & (ex_dst != '0) &
                      ((ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt)));

    // State and down-counter registers; reset drains the pipeline to RUN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode; outputs act in the cycle the hazard is seen.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        hazard_state = 2'b00;

        case (state_q)
            ST_STALL: begin
                hazard_state = 2'b01;
                if (ex_redirect) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (FLUSH_USE) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_RELOAD;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = 3'd0;
                    end
                end else begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (cnt_q <= 3'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end

            ST_FLUSH: begin
                // The ID instruction is wrong-path here, so load_use is ignored.
                hazard_state = 2'b10;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                if (ex_redirect) begin
                    cnt_d = FLUSH_RELOAD;
                end else if (cnt_q <= 3'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            default: begin
                // RUN, and the unreachable encoding 11 which recovers as RUN.
                state_d = ST_RUN;
                if (ex_redirect) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (FLUSH_USE) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_RELOAD;
                    end
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    if (STALL_USE) begin
                        state_d = ST_STALL;
                        cnt_d   = STALL_RELOAD;
                    end
                end
            end
        endcase

        // While reset is held the pipeline is drained regardless of state.
        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            hazard_state = 2'b00;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_cycles_q;

    // Stall cycles are bubbles without a flush; both counters wrap naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= 32'd0;
            flush_cycles_q <= 32'd0;
        end else begin
            if (id_ex_bubble & ~if_id_flush)
                stall_cycles_q <= stall_cycles_q + 32'd1;
            if (if_id_flush)
                flush_cycles_q <= flush_cycles_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_unit.sv
// Bench for id_ex_hazard_unit: two instances share stimulus, one with the
// default 1-cycle stall/flush lengths and one with 3-cycle lengths.
// Expected output words are {pc_write, if_id_write, if_id_flush,
// id_ex_bubble, hazard_state[1:0]}.
module tb_id_ex_hazard_unit;

    localparam logic [5:0] E_RUN   = 6'b1100_00;
    localparam logic [5:0] E_STL_R = 6'b0001_00;
    localparam logic [5:0] E_STL_S = 6'b0001_01;
    localparam logic [5:0] E_RED_R = 6'b1111_00;
    localparam logic [5:0] E_RED_S = 6'b1111_01;
    localparam logic [5:0] E_RED_F = 6'b1111_10;
    localparam logic [5:0] E_RST   = 6'b0011_00;

    typedef struct {
        logic       rst_n;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mem_read;
        logic       reg_write;
        logic [4:0] dst;
        logic       redirect;
        logic [5:0] exp1;
        logic [5:0] exp3;
    } vec_t;

    typedef struct {
        int         idx;
        logic [5:0] exp1;
        logic [5:0] exp3;
    } sb_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_dst = '0;
    logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_reg_write = 1'b0, ex_redirect = 1'b0;

    logic pc1, ifw1, fl1, bub1, pc3, ifw3, fl3, bub3;
    logic [1:0] st1, st3;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc1, fc1, sc3, fc3;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    sb_t sb[$];

    always #5 clock = ~clock;

    id_ex_hazard_unit #(.REG_W(5), .LOAD_STALL_CYCS(1), .FLUSH_CYCS(1)) dut1 (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_dst(ex_dst), .ex_redirect(ex_redirect), .pc_write(pc1), .if_id_write(ifw1),
        .if_id_flush(fl1), .id_ex_bubble(bub1), .hazard_state(st1)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc1), .flush_cycles(fc1)
`endif
    );

    id_ex_hazard_unit #(.REG_W(5), .LOAD_STALL_CYCS(3), .FLUSH_CYCS(3)) dut3 (
        .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_dst(ex_dst), .ex_redirect(ex_redirect), .pc_write(pc3), .if_id_write(ifw3),
        .if_id_flush(fl3), .id_ex_bubble(bub3), .hazard_state(st3)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc3), .flush_cycles(fc3)
`endif
    );

    function automatic vec_t mk(input logic rst_n, input logic [4:0] rs, input logic [4:0] rt,
                                input logic uses_rt, input logic mem_read, input logic reg_write,
                                input logic [4:0] dst, input logic redirect,
                                input logic [5:0] exp1, input logic [5:0] exp3);
        vec_t v;
        v.rst_n = rst_n; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt;
        v.mem_read = mem_read; v.reg_write = reg_write; v.dst = dst;
        v.redirect = redirect; v.exp1 = exp1; v.exp3 = exp3;
        return v;
    endfunction

    // Drive one cycle of stimulus at the falling edge, then check both DUTs.
    task automatic apply(input vec_t v, input int idx);
        sb_t e;
        logic [5:0] a1, a3;
        @(negedge clock);
        reset        = v.rst_n;
        id_rs        = v.rs;
        id_rt        = v.rt;
        id_uses_rt   = v.uses_rt;
        ex_mem_read  = v.mem_read;
        ex_reg_write = v.reg_write;
        ex_dst       = v.dst;
        ex_redirect  = v.redirect;
        e.idx = idx; e.exp1 = v.exp1; e.exp3 = v.exp3;
        sb.push_back(e);
        #2;
        e  = sb.pop_front();
        a1 = {pc1, ifw1, fl1, bub1, st1};
        a3 = {pc3, ifw3, fl3, bub3, st3};
        n_tests++;
        if (a1 !== e.exp1) begin
            n_fail++;
            $display("FAIL vec%0d dut1 outputs: got %b required %b", e.idx, a1, e.exp1);
        end
        n_tests++;
        if (a3 !== e.exp3) begin
            n_fail++;
            $display("FAIL vec%0d dut3 outputs: got %b required %b", e.idx, a3, e.exp3);
        end
        $display("[TB] vec%0d rst_n=%0b rs=%0d rt=%0d ur=%0b mr=%0b rw=%0b dst=%0d red=%0b dut1=%b dut3=%b",
                 e.idx, v.rst_n, v.rs, v.rt, v.uses_rt, v.mem_read, v.reg_write, v.dst, v.redirect, a1, a3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[28];
        vec_t idle, lu;
        idle = mk(1, 0, 0, 0, 0, 0, 0, 0, E_RUN, E_RUN);
        lu   = mk(1, 8, 0, 0, 1, 1, 8, 0, E_STL_R, E_STL_R);

        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, E_RST,   E_RST);    // in reset
        tbl[1]  = idle;
        tbl[2]  = lu;                                           // dut3 -> STALL cnt 2
        tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, E_RUN,   E_STL_S);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0, 0, E_RUN,   E_STL_S);
        tbl[5]  = idle;
        tbl[6]  = mk(1, 0, 0, 0, 1, 1, 0, 0, E_RUN,   E_RUN);    // dst r0
        tbl[7]  = mk(1, 3, 8, 0, 1, 1, 8, 0, E_RUN,   E_RUN);    // rt unused
        tbl[8]  = mk(1, 3, 8, 1, 1, 1, 8, 0, E_STL_R, E_STL_R);  // rt used
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, E_RUN,   E_STL_S);
        tbl[10] = mk(1, 0, 0, 0, 0, 0, 0, 0, E_RUN,   E_STL_S);
        tbl[11] = mk(1, 8, 0, 0, 1, 0, 8, 0, E_RUN,   E_RUN);    // bubbled EX
        tbl[12] = mk(1, 8, 0, 0, 0, 1, 8, 0, E_RUN,   E_RUN);    // not a load
        tbl[13] = mk(1, 8, 0, 0, 1, 1, 8, 1, E_RED_R, E_RED_R);  // redirect beats load-use
        tbl[14] = mk(1, 8, 0, 0, 1, 1, 8, 0, E_STL_R, E_RED_F);  // load-use ignored in FLUSH
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, E_RUN,   E_RED_F);
        tbl[16] = idle;
        tbl[17] = mk(1, 0, 0, 0, 0, 0, 0, 1, E_RED_R, E_RED_R);
        tbl[18] = mk(1, 0, 0, 0, 0, 0, 0, 0, E_RUN,   E_RED_F);
        tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, 1, E_RED_R, E_RED_F);  // reload in FLUSH
        tbl[20] = mk(1, 0, 0, 0, 0, 0, 0, 0, E_RUN,   E_RED_F);
        tbl[21] = mk(1, 0, 0, 0, 0, 0, 0, 0, E_RUN,   E_RED_F);
        tbl[22] = idle;
        tbl[23] = lu;
        tbl[24] = mk(1, 0, 0, 0, 0, 0, 0, 1, E_RED_R, E_RED_S);  // redirect in STALL
        tbl[25] = mk(1, 0, 0, 0, 0, 0, 0, 0, E_RUN,   E_RED_F);
        tbl[26] = mk(1, 0, 0, 0, 0, 0, 0, 0, E_RUN,   E_RED_F);
        tbl[27] = idle;

        for (int i = 0; i < 28; i++) apply(tbl[i], i);

        // Reset asserted while dut3 is in STALL with cnt = 2.
        apply(lu, 100);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, E_RST, E_RST), 101);
        apply(idle, 102);
        apply(idle, 103);

`ifdef HAZARD_PERF_CNT_EN
        // Counters were cleared by the reset above.
        apply(lu, 200);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 1, E_RED_R, E_RED_S), 201);
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, E_RUN, E_RED_F), 202);
        n_tests++;
        if (sc1 !== 32'd1) begin
            n_fail++;
            $display("FAIL perf stall_cycles: got %0d required 1", sc1);
        end
        n_tests++;
        if (fc1 !== 32'd1) begin
            n_fail++;
            $display("FAIL perf flush_cycles: got %0d required 1", fc1);
        end
        apply(mk(1, 0, 0, 0, 0, 0, 0, 1, E_RED_R, E_RED_F), 203);
        dut1.flush_cycles_q = 32'hFFFF_FFFF;
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, E_RUN, E_RED_F), 204);
        n_tests++;
        if (fc1 !== 32'd0) begin
            n_fail++;
            $display("FAIL perf flush_wrap: got %0h required 0", fc1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
